// File: rtl/ct_spsram_128x16_ctrl.sv
// ct_spsram_128x16_ctrl
// Initiator-side access controller for a single-port SRAM macro with
// active-low CEN/GWEN and active-low per-bit WEN, one-cycle read latency.
// After reset every entry is swept to zero; afterwards read/write requests
// arrive on a valid/ready port and read data leaves on a valid/ready
// response port that may be backpressured. One read in flight at most.
module ct_spsram_128x16_ctrl #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  req_vld,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_wmask,
  output logic                  req_rdy,
  output logic                  rsp_vld,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  input  logic                  rsp_rdy,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  // INIT : zero sweep in progress
  // IDLE : ready for a request; writes complete here in one cycle
  // RD   : read data is on sram_q this cycle, forwarded straight through
  // HOLD : response stalled by rsp_rdy, data replayed from hold_q
  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_RD   = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;
  localparam logic [ADDR_WIDTH-1:0] CNT_ONE  = ADDR_WIDTH'(1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q,   cnt_d;
  logic [DATA_WIDTH-1:0] hold_q,  hold_d;

  // State, sweep counter and hold register; reset restarts the sweep and
  // discards any response that was waiting.
  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
    end
  end

  // Next-state logic: sweep progress, read issue, response handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        // Writes finish at the accept edge, only reads leave IDLE.
        if (req_vld && !req_wr) begin
          state_d = ST_RD;
        end
      end
      ST_RD: begin
        if (rsp_rdy) begin
          state_d = ST_IDLE;
        end else begin
          // sram_q is only guaranteed this one cycle, so keep a copy.
          hold_d  = sram_q;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (rsp_rdy) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Handshake and SRAM pin drive; the macro is parked (CEN high, all
  // enables inactive, address/data zero) whenever no access is issued,
  // and unconditionally while reset is asserted.
  always_comb begin
    req_rdy   = 1'b0;
    rsp_vld   = 1'b0;
    rsp_rdata = '0;
    init_done = 1'b0;
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = '0;
    sram_d    = '0;
    if (cpurst_b) begin
      case (state_q)
        ST_INIT: begin
          sram_cen  = 1'b0;
          sram_gwen = 1'b0;
          sram_wen  = '0;
          sram_a    = cnt_q;
          sram_d    = '0;
        end
        ST_IDLE: begin
          req_rdy   = 1'b1;
          init_done = 1'b1;
          if (req_vld) begin
            sram_cen = 1'b0;
            sram_a   = req_addr;
            if (req_wr) begin
              sram_gwen = 1'b0;
              sram_wen  = ~req_wmask;
              sram_d    = req_wdata;
            end
          end
        end
        ST_RD: begin
          init_done = 1'b1;
          rsp_vld   = 1'b1;
          rsp_rdata = sram_q;
        end
        ST_HOLD: begin
          init_done = 1'b1;
          rsp_vld   = 1'b1;
          rsp_rdata = hold_q;
        end
        default: begin
          init_done = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ct_spsram_128x16_ctrl.sv
// Bench for ct_spsram_128x16_ctrl: behavioural SRAM macro, reference memory
// updated at request acceptance, response scoreboard with separate monitor.
module tb_ct_spsram_128x16_ctrl;
  localparam int AW = 7;
  localparam int DW = 16;
  localparam int DEPTH = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          cpurst_b = 1'b0;
  logic          req_vld = 1'b0;
  logic          req_wr = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [DW-1:0] req_wmask = '0;
  logic          req_rdy;
  logic          rsp_vld;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_rdy;
  logic          init_done;
  logic [AW-1:0] sram_a;
  logic          sram_cen;
  logic          sram_gwen;
  logic [DW-1:0] sram_wen;
  logic [DW-1:0] sram_d;
  logic [DW-1:0] sram_q;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] exp_q [$];

  bit   rdy_mode = 1'b0;   // 1: random rsp_rdy, 0: rdy_force
  logic rdy_force = 1'b1;

  ct_spsram_128x16_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .forever_cpuclk(clk),
    .cpurst_b(cpurst_b),
    .req_vld(req_vld),
    .req_wr(req_wr),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_wmask(req_wmask),
    .req_rdy(req_rdy),
    .rsp_vld(rsp_vld),
    .rsp_rdata(rsp_rdata),
    .rsp_rdy(rsp_rdy),
    .init_done(init_done),
    .sram_a(sram_a),
    .sram_cen(sram_cen),
    .sram_gwen(sram_gwen),
    .sram_wen(sram_wen),
    .sram_d(sram_d),
    .sram_q(sram_q)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // rsp_rdy driver
  always @(posedge clk) begin
    #2;
    rsp_rdy = rdy_mode ? 1'($urandom_range(0, 1)) : rdy_force;
  end

  // SRAM macro model: starts full of garbage, q is garbage except the
  // cycle right after a read access.
  logic [DW-1:0] mem [DEPTH];
  bit mem_filled = 1'b0;
  always @(posedge clk) begin
    if (!mem_filled) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
      mem_filled = 1'b1;
    end
    if (!sram_cen && !sram_gwen)
      mem[sram_a] = (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
    if (!sram_cen && sram_gwen) sram_q <= mem[sram_a];
    else                        sram_q <= DW'($urandom);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: pops the scoreboard at each handshake, checks
  // stability under backpressure and idle/busy pin state.
  bit            pend = 1'b0;
  logic [DW-1:0] pend_data;
  always @(negedge clk) begin
    if (!cpurst_b) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        chk("bp_vld", 64'(rsp_vld), 64'(1));
        chk("bp_data", 64'(rsp_rdata), 64'(pend_data));
      end
      pend = 1'b0;
      if (rsp_vld) begin
        chk("busy_pins", 64'({sram_cen, req_rdy}), 64'(2'b10));
        if (rsp_rdy) begin
          chk("rsp_q_nonempty", 64'(exp_q.size() != 0), 64'(1));
          if (exp_q.size() != 0) begin
            logic [DW-1:0] e;
            e = exp_q.pop_front();
            chk("rsp_data", 64'(rsp_rdata), 64'(e));
            $display("rsp data=%h exp=%h", rsp_rdata, e);
          end
        end else begin
          pend = 1'b1;
          pend_data = rsp_rdata;
        end
      end else if (init_done && !req_vld) begin
        chk("idle_pins", 64'({sram_cen, sram_gwen, sram_wen, sram_d, sram_a}),
            64'({1'b1, 1'b1, {DW{1'b1}}, {DW{1'b0}}, {AW{1'b0}}}));
      end
    end
  end

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    cpurst_b = 1'b0;
    req_vld = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("rst_rsp_vld", 64'(rsp_vld), 64'(0));
    chk("rst_init_done", 64'(init_done), 64'(0));
    chk("rst_req_rdy", 64'(req_rdy), 64'(0));
    repeat (n) begin
      @(negedge clk);
      chk("rst_cen", 64'(sram_cen), 64'(1));
    end
    @(posedge clk); #1;
    cpurst_b = 1'b1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    $display("reset released after %0d cycles", n + 1);
  endtask

  // Follows the sweep; stop_at >= 0 abandons it at that entry.
  task automatic sweep(input int stop_at);
    int idx = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (stop_at >= 0 && idx == stop_at) begin
        $display("sweep interrupted at entry %0d", idx);
        return;
      end
      if (init_done) break;
      chk("sweep_pins", 64'({sram_cen, sram_gwen, sram_wen, sram_d, sram_a}),
          64'({1'b0, 1'b0, {DW{1'b0}}, {DW{1'b0}}, AW'(idx)}));
      idx++;
    end
    chk("sweep_len", 64'(idx), 64'(128));
    chk("sweep_req_rdy", 64'(req_rdy), 64'(1));
    $display("sweep complete: %0d writes", idx);
    @(posedge clk); #1;
  endtask

  task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input logic [DW-1:0] wm, output int acc_cyc);
    bit acc = 1'b0;
    req_vld = 1'b1; req_wr = wr; req_addr = a; req_wdata = wd; req_wmask = wm;
    acc_cyc = -1;
    for (int w = 0; w < 64; w++) begin
      @(negedge clk);
      if (req_rdy) begin acc = 1'b1; break; end
    end
    chk("req_accept", 64'(acc), 64'(1));
    if (acc) begin
      acc_cyc = cyc;
      if (wr) begin
        chk("wr_pins", 64'({sram_cen, sram_gwen, sram_a, sram_wen, sram_d}),
            64'({1'b0, 1'b0, a, ~wm, wd}));
        ref_mem[a] = (ref_mem[a] & ~wm) | (wd & wm);
      end else begin
        chk("rd_pins", 64'({sram_cen, sram_gwen, sram_a, sram_wen}),
            64'({1'b0, 1'b1, a, {DW{1'b1}}}));
        exp_q.push_back(ref_mem[a]);
      end
      $display("req %s addr=%h wdata=%h wmask=%h", wr ? "WR" : "RD", a, wd, wm);
    end
    @(posedge clk); #1;
    req_vld = 1'b0;
  endtask

  task automatic directed_read(input logic [AW-1:0] a, input int stall, input logic [DW-1:0] exp);
    int c;
    rdy_force = (stall == 0);
    issue(1'b0, a, '0, '0, c);
    @(negedge clk);
    chk("rd_n1", 64'({rsp_vld, req_rdy}), 64'(2'b10));
    if (stall == 0) begin
      chk("rd_data", 64'(rsp_rdata), 64'(exp));
    end else begin
      for (int i = 1; i < stall; i++) begin
        @(posedge clk); #1;
        @(negedge clk);
        chk("rd_stall", 64'({rsp_vld, req_rdy, rsp_rdata}), 64'({1'b1, 1'b0, exp}));
      end
      @(posedge clk); #1;
      rdy_force = 1'b1;
      @(negedge clk);
      chk("rd_release", 64'({rsp_vld, rsp_rdata}), 64'({1'b1, exp}));
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("rd_back_idle", 64'({req_rdy, rsp_vld}), 64'(2'b10));
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cy [4];
    int c;
    do_reset(3);
    sweep(-1);
    directed_read(7'h55, 0, 16'h0000);

    issue(1'b1, 7'h12, 16'hA5C3, 16'hFFFF, c);
    directed_read(7'h12, 0, 16'hA5C3);
    issue(1'b1, 7'h12, 16'h0000, 16'h00FF, c);
    directed_read(7'h12, 0, 16'hA500);
    directed_read(7'h12, 5, 16'hA500);

    for (int i = 0; i < 4; i++) issue(1'b1, AW'(i), DW'(16'h1111 * (i + 1)), 16'hFFFF, cy[i]);
    for (int i = 1; i < 4; i++) chk("b2b_cycle", 64'(cy[i] - cy[i-1]), 64'(1));
    for (int i = 0; i < 4; i++) directed_read(AW'(i), 0, DW'(16'h1111 * (i + 1)));

    issue(1'b1, 7'h12, 16'hFFFF, 16'h0000, c);
    directed_read(7'h12, 0, 16'hA500);

    // Randomised traffic with random backpressure
    rdy_mode = 1'b1;
    for (int t = 0; t < 250; t++) begin
      logic [AW-1:0] a;
      a = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      issue(1'($urandom_range(0, 1)), a, DW'($urandom), DW'($urandom), c);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    rdy_mode = 1'b0;
    rdy_force = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("drain", 64'(exp_q.size()), 64'(0));

    // Reset part-way through the sweep
    do_reset(2);
    sweep(60);
    do_reset(2);
    sweep(-1);
    directed_read(7'h12, 0, 16'h0000);

    // Reset while a response is held
    issue(1'b1, 7'h03, 16'hBEEF, 16'hFFFF, c);
    rdy_force = 1'b0;
    issue(1'b0, 7'h03, '0, '0, c);
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("hold_before_rst", 64'({rsp_vld, rsp_rdata}), 64'({1'b1, 16'hBEEF}));
    do_reset(3);
    rdy_force = 1'b1;
    sweep(-1);
    directed_read(7'h03, 0, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ct_spsram_128x16_ctrl.md
# ct_spsram_128x16_ctrl

Access controller on the initiator side of a 128-entry x 16-bit single-port SRAM (active-low CEN/GWEN/per-bit WEN, one-cycle read latency). After reset it sweeps every entry to zero. It then accepts read/write requests through a valid/ready handshake and returns read data through a valid/ready response port with backpressure. It sits between IFU table logic and the SRAM macro wrapper.

## Interface
Parameters:
- ADDR_WIDTH, 7, SRAM address width; depth is 2^ADDR_WIDTH.
- DATA_WIDTH, 16, data width; also the WEN width, one bit per data bit.

Ports:
- forever_cpuclk  in  1  sole clock.
- cpurst_b  in  1  reset, synchronous, active-low.
- req_vld  in  1  request valid.
- req_wr  in  1  1 = write, 0 = read.
- req_addr  in  7  entry address.
- req_wdata  in  16  write data.
- req_wmask  in  16  per-bit write enable, 1 = write that bit.
- req_rdy  out  1  request accepted when req_vld & req_rdy.
- rsp_vld  out  1  read data valid.
- rsp_rdata  out  16  read data.
- rsp_rdy  in  1  response consumed when rsp_vld & rsp_rdy.
- init_done  out  1  sweep complete.
- sram_a  out  7  SRAM address.
- sram_cen  out  1  chip enable, active-low.
- sram_gwen  out  1  global write enable, active-low.
- sram_wen  out  16  bit write enables, active-low.
- sram_d  out  16  SRAM write data.
- sram_q  in  16  SRAM read data, valid the cycle after a read access.

## Operation
- States: INIT, IDLE, RD, HOLD. A 7-bit sweep counter `cnt` is used in INIT.
- Reset: while cpurst_b = 0, the state is forced to INIT at every clock edge, `cnt` is cleared, and the hold register is cleared. Combinationally, sram_cen = 1 whenever cpurst_b = 0.
- Output values out of reset: req_rdy = 0, rsp_vld = 0, init_done = 0, rsp_rdata = 0.
- INIT behaviour:
  - Every cycle drives sram_cen = 0, sram_gwen = 0, sram_wen = 16'h0000, sram_a = cnt, sram_d = 0.
  - `cnt` increments each cycle.
  - When cnt = 127, the next state is IDLE.
  - req_rdy = 0 throughout.
- IDLE behaviour:
  - req_rdy = 1 and init_done = 1. init_done stays at 1 until the next reset.
  - When req_vld = 1, the access is issued the same cycle, combinationally:
    - sram_cen = 0, sram_a = req_addr.
    - Write: sram_gwen = 0, sram_wen = ~req_wmask, sram_d = req_wdata.
    - Read: sram_gwen = 1, sram_wen = 16'hFFFF.
  - A write remains in IDLE. Back-to-back writes run at one per cycle. A write with req_wmask = 0 is still issued and changes no bits. Writes produce no response.
  - A read moves to RD.
  - When req_vld = 0: sram_cen = 1 and sram_gwen = 1.
- RD behaviour:
  - rsp_vld = 1 and rsp_rdata = sram_q, as a bypass.
  - req_rdy = 0 and sram_cen = 1.
  - If rsp_rdy = 1, the next state is IDLE.
  - Otherwise sram_q is captured into the hold register and the next state is HOLD.
- HOLD behaviour:
  - rsp_vld = 1 and rsp_rdata = hold register.
  - req_rdy = 0 and sram_cen = 1.
  - The next state is IDLE on rsp_rdy = 1.
- When the SRAM is idle (sram_cen = 1), sram_gwen = 1, sram_wen = 16'hFFFF, sram_d = 0, and sram_a = 0.
- At most one read is outstanding.

## Timing
- Sweep length: reset deasserted before edge E0. INIT writes occupy cycles 0..127 after E0. init_done and req_rdy rise in cycle 128.
- Write latency: SRAM update at the edge that ends the accept cycle. Throughput is one write per cycle.
- Read latency: accept in cycle N. rsp_vld = 1 in cycle N+1 with sram_q data. With rsp_rdy = 1 in N+1, req_rdy = 1 again in N+2, so read throughput is one read per 2 cycles.
- Backpressure: rsp_rdata stays stable and rsp_vld stays high from N+1 until the rsp_rdy handshake cycle inclusive.
- Reset asserted mid-sweep, in RD, or in HOLD:
  - Any pending response is dropped.
  - rsp_vld = 0 at the next edge.
  - The full 128-entry sweep restarts from entry 0.

## Test plan
- Reset, then run to completion → exactly 128 writes (sram_cen = 0, sram_gwen = 0, sram_d = 0, addresses 0..127 in order); init_done = 1 and req_rdy = 1 in cycle 128; a read of address 7'h55 returns 16'h0000.
- Write addr 7'h12, wdata 16'hA5C3, wmask 16'hFFFF; then read 7'h12 with rsp_rdy = 1 → rsp_vld for one cycle with 16'hA5C3; req_rdy low exactly one cycle.
- Write 7'h12 with wdata 16'h0000, wmask 16'h00FF; then read → 16'hA500, which proves the sram_wen = ~mask polarity.
- Read 7'h12 with rsp_rdy held low for 5 cycles while sram_q is toggled randomly → rsp_rdata stays 16'hA500 and req_rdy stays 0; after rsp_rdy = 1, IDLE the next cycle.
- Four back-to-back writes to 7'h00..7'h03, wdata 16'h1111..16'h4444 → four consecutive sram_cen = 0 cycles; the reads return the matching values.
- Assert cpurst_b = 0 at sweep cycle 60, and separately in HOLD → rsp_vld = 0 and init_done = 0 next edge; sram_cen = 1 while in reset; the sweep restarts from address 0 and takes 128 cycles.
